// File: rtl/div_sched_pkg.sv
// Shared types and constants for the two-requester divider scheduler.
package div_sched_pkg;

  // Default operand width; also the number of datapath step cycles.
  localparam int unsigned DIV_WIDTH = 32;

  // Widest operand width the divide-by-zero quotient constant covers.
  localparam int unsigned DBZ_MAX_WIDTH = 64;

  // Quotient reported for a divide-by-zero; users slice it down to WIDTH bits.
  localparam logic [DBZ_MAX_WIDTH-1:0] DBZ_QUOT = '1;

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone request always wins;
// when both requesters are active, ptr decides the winner.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick the winner; grant stays one-hot or zero.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant      = 2'b00;
      grant[ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Shares one external iterative unsigned divider between two requesters:
// round-robin grant, operand latch, load/step sequencing, and a registered
// one-cycle response pulse. Divide-by-zero skips the datapath entirely.
module div_share_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_dividend,
  input  logic [2*WIDTH-1:0] req_divisor,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_quot,
  output logic [WIDTH-1:0]   rsp_rem,
  output logic               rsp_dbz,
  output logic [WIDTH-1:0]   dp_dividend,
  output logic [WIDTH-1:0]   dp_divisor,
  output logic               dp_load,
  output logic               dp_step,
  input  logic [WIDTH-1:0]   dp_quot,
  input  logic [WIDTH-1:0]   dp_rem
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               owner_q, owner_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_quot_q, rsp_quot_d;
  logic [WIDTH-1:0]   rsp_rem_q, rsp_rem_d;
  logic               rsp_dbz_q, rsp_dbz_d;

  logic [1:0]         grant;
  logic               gnt_idx;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;

  rr_arb2 u_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign gnt_idx      = grant[1];
  assign sel_dividend = gnt_idx ? req_dividend[WIDTH +: WIDTH] : req_dividend[0 +: WIDTH];
  assign sel_divisor  = gnt_idx ? req_divisor[WIDTH +: WIDTH]  : req_divisor[0 +: WIDTH];

  // Handshake and datapath strobes are pure state decodes, so they are mutually exclusive.
  assign req_ready   = (state_q == IDLE) ? grant : 2'b00;
  assign dp_load     = (state_q == LOAD);
  assign dp_step     = (state_q == ITER);
  assign dp_dividend = dividend_q;
  assign dp_divisor  = divisor_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_quot    = rsp_quot_q;
  assign rsp_rem     = rsp_rem_q;
  assign rsp_dbz     = rsp_dbz_q;

  // Next-state logic for the sequencer, operand latch and response registers.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    owner_d     = owner_q;
    dbz_d       = dbz_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rsp_valid_d = 2'b00;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_dbz_d   = rsp_dbz_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d    = gnt_idx;
          ptr_d      = ~gnt_idx;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          dbz_d      = (sel_divisor == '0);
          state_d    = (sel_divisor == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        count_d = '0;
        state_d = ITER;
      end
      ITER: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_quot_d = dbz_q ? DBZ_QUOT[WIDTH-1:0] : dp_quot;
        rsp_rem_d  = dbz_q ? dividend_q : dp_rem;
        rsp_dbz_d  = dbz_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      count_q     <= '0;
      owner_q     <= 1'b0;
      dbz_q       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rsp_valid_q <= 2'b00;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      owner_q     <= owner_d;
      dbz_q       <= dbz_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_dbz_q   <= rsp_dbz_d;
    end
  end

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched with a behavioural restoring divider
// standing in for the shared datapath.
module tb_div_share_sched;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_dividend, req_divisor;
  logic [1:0]     req_ready, rsp_valid;
  logic [W-1:0]   rsp_quot, rsp_rem, dp_dividend, dp_divisor, dp_quot, dp_rem;
  logic           rsp_dbz, dp_load, dp_step;

  logic           v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0]   dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;

  assign req_valid    = {v1, v0};
  assign req_dividend = {dvd1, dvd0};
  assign req_divisor  = {dvs1, dvs0};

  div_share_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz),
    .dp_dividend(dp_dividend), .dp_divisor(dp_divisor),
    .dp_load(dp_load), .dp_step(dp_step),
    .dp_quot(dp_quot), .dp_rem(dp_rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Restoring shift/subtract divider model.
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [W:0]   t_r;
  logic [W-1:0] t_q;
  always @(posedge clk) begin
    if (dp_load) begin
      m_q <= dp_dividend;
      m_r <= '0;
    end else if (dp_step) begin
      t_r = {m_r, m_q[W-1]};
      t_q = {m_q[W-2:0], 1'b0};
      if (t_r >= {1'b0, dp_divisor}) begin
        t_r  = t_r - {1'b0, dp_divisor};
        t_q[0] = 1'b1;
      end
      m_r <= t_r[W-1:0];
      m_q <= t_q;
    end
  end
  assign dp_quot = m_q;
  assign dp_rem  = m_r;

  typedef struct {
    int           owner;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dbz;
    int           exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_load  = 0;
  int   n_step  = 0;
  bit   excl_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check({tag, "_rsp_quot"}, 64'(rsp_quot), 0);
    check({tag, "_rsp_rem"}, 64'(rsp_rem), 0);
    check({tag, "_rsp_dbz"}, 64'(rsp_dbz), 0);
    check({tag, "_dp_dividend"}, 64'(dp_dividend), 0);
    check({tag, "_dp_divisor"}, 64'(dp_divisor), 0);
    check({tag, "_dp_strobes"}, 64'({dp_load, dp_step}), 0);
  endtask

  // Monitor: pops the scoreboard on every response and checks data, latency and datapath usage.
  always @(negedge clk) begin
    if (!rst) begin
      n_load = 0;
      n_step = 0;
    end else begin
      if (dp_load) n_load++;
      if (dp_step) n_step++;
      if (int'(dp_load) + int'(dp_step) + int'(|req_ready) > 1 || req_ready == 2'b11)
        excl_bad = 1'b1;
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << e.owner));
          check("rsp_quot", 64'(rsp_quot), 64'(e.quot));
          check("rsp_rem", 64'(rsp_rem), 64'(e.rem));
          check("rsp_dbz", 64'(rsp_dbz), 64'(e.dbz));
          check("rsp_latency_cycle", 64'(cyc), 64'(e.exp_cyc));
          check("dp_load_cycles", 64'(n_load), e.dbz ? 64'd0 : 64'd1);
          check("dp_step_cycles", 64'(n_step), e.dbz ? 64'd0 : 64'(W));
        end
        n_load = 0;
        n_step = 0;
      end
    end
  end

  // Presents one request, waits for its accept, optionally records the expectation.
  task automatic drive(input int i, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                       input bit hold, input bit push, output int acc_cyc);
    bit got = 1'b0;
    if (i == 0) begin dvd0 = dvd; dvs0 = dvs; v0 = 1'b1; end
    else        begin dvd1 = dvd; dvs1 = dvs; v1 = 1'b1; end
    acc_cyc = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 64'(i), 64'(i + 100));
    end else begin
      acc_cyc = cyc;
      grant_log.push_back(i);
      if (push) sb.push_back('{owner: i, quot: q, rem: r, dbz: dbz,
                               exp_cyc: cyc + (dbz ? 2 : W + 3)});
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (i == 0) v0 = 1'b0; else v1 = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    check("drain_pending", 64'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: lone request 100/7, then the result is held after the pulse.
    drive(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1, a0);
    drain();
    check("hold_quot", 64'(rsp_quot), 64'd14);
    check("hold_rem", 64'(rsp_rem), 64'd2);

    // 2: both valid right after reset; req0 first, req1 in the response cycle.
    do_reset();
    grant_log.delete();
    fork
      drive(0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b0, 1'b1, a0);
      drive(1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b0, 1'b1, a1);
    join
    check("t2_second_grant_cycle", 64'(a1 - a0), 64'(W + 3));
    drain();
    check("t2_grant_order", 64'({grant_log[0][3:0], grant_log[1][3:0]}), 64'h01);

    // 3: divide by zero on requester 1.
    drive(1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1'b1, a0);
    drain();

    // 4: boundary operands.
    drive(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, a0);
    drive(0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, 1'b1, a0);
    drain();

    // 5: reset while ITER has count==10, then re-issue.
    drive(0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 1'b0, a0);
    repeat (11) @(posedge clk);
    #1;
    check("t5_steps_before_abort", 64'(n_step), 64'd10);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    repeat (40) @(posedge clk);
    #1;
    drive(0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 1'b1, a0);
    drain();

    // 6: req0 held for two ops, req1 arrives mid-operation; grants alternate.
    grant_log.delete();
    fork
      begin
        drive(0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b1, 1'b1, a0);
        drive(0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b0, 1'b1, a2);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        drive(1, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1'b1, 1'b1, a1);
        drive(1, 32'd63, 32'd8, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, a3);
      end
    join
    drain();
    check("t6_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4)
      check("t6_grant_order", 64'({grant_log[0][3:0], grant_log[1][3:0],
                                   grant_log[2][3:0], grant_log[3][3:0]}), 64'h0101);

    check("decode_exclusive", 64'(excl_bad), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
